// File: rtl/tdm_demux8x1.sv
// -----------------------------------------------------------------------------
// tdm_demux8x1
// Receive end of an 8-slot, 1-bit TDM serial link. Finds frame alignment from
// the fsync strobe, steps a 3-bit slot counter on every valid beat, collects
// the beats in a shadow register and presents one whole frame on o1..o8 at a
// time. A flywheel tolerates up to SYNC_LOSS-1 consecutive fsync mismatches
// before lock is dropped.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous reset, active-low
//   din          serial data bit for the current slot
//   din_valid    qualifies din/fsync this cycle (a "beat")
//   fsync        high on the beat carrying slot 0
//   o1..o8       channel bits of the last complete frame (slot 0 -> o1)
//   s0,s1,s2     slot expected on the next beat, s0 is the MSB
//   frame_valid  one-cycle pulse when o1..o8 update
//   locked       high while frame alignment is held
//   sync_err     one-cycle pulse on loss of lock
// -----------------------------------------------------------------------------
module tdm_demux8x1 #(
    parameter int SYNC_LOSS = 2     // consecutive mismatches that drop lock, 1..15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic din_valid,
    input  logic fsync,
    output logic o1,
    output logic o2,
    output logic o3,
    output logic o4,
    output logic o5,
    output logic o6,
    output logic o7,
    output logic o8,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic frame_valid,
    output logic locked,
    output logic sync_err
);

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [4:0] LOSS_LIMIT = 5'(SYNC_LOSS);

    state_t     r_state;
    logic [2:0] r_slot;
    logic [3:0] r_miss;
    logic [6:0] r_shadow;      // slot 7 never needs storing: it arrives with the frame
    logic [7:0] r_out;
    logic       r_frame_valid;
    logic       r_sync_err;
    logic       r_locked;

    logic       w_slot_zero;
    logic       w_mismatch;
    logic [4:0] w_miss_inc;
    logic       w_loss;
    logic [6:0] w_hit;

    assign w_slot_zero = (r_slot == 3'd0);
    // fsync is expected exactly on slot 0; anything else is a mismatch
    assign w_mismatch  = fsync ? !w_slot_zero : w_slot_zero;
    assign w_miss_inc  = {1'b0, r_miss} + 5'd1;
    assign w_loss      = w_mismatch && (w_miss_inc >= LOSS_LIMIT);

    // one-hot decode of the shadow bit written by the current beat
    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_hit
            assign w_hit[gi] = (r_slot == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_HUNT;
            r_slot        <= 3'd0;
            r_miss        <= 4'd0;
            r_shadow      <= 7'd0;
            r_out         <= 8'd0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            if (din_valid) begin
                case (r_state)
                    ST_HUNT: begin
                        if (fsync) begin
                            r_shadow <= {6'd0, din};
                            r_slot   <= 3'd1;
                            r_miss   <= 4'd0;
                            r_state  <= ST_LOCKED;
                            r_locked <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_loss) begin
                            r_sync_err <= 1'b1;
                            r_miss     <= 4'd0;
                            if (fsync) begin
                                // the strobe itself marks a new slot 0: realign at once
                                r_shadow <= {6'd0, din};
                                r_slot   <= 3'd1;
                            end else begin
                                r_shadow <= 7'd0;
                                r_slot   <= 3'd0;
                                r_state  <= ST_HUNT;
                                r_locked <= 1'b0;
                            end
                        end else begin
                            for (int i = 0; i < 7; i++) begin
                                if (w_hit[i]) begin
                                    r_shadow[i] <= din;
                                end
                            end
                            if (w_mismatch) begin
                                r_miss <= w_miss_inc[3:0];
                            end else if (w_slot_zero) begin
                                r_miss <= 4'd0;
                            end
                            if (r_slot == 3'd7) begin
                                r_out         <= {din, r_shadow};
                                r_frame_valid <= 1'b1;
                            end
                            r_slot <= r_slot + 3'd1;   // 7 wraps to 0
                        end
                    end
                    default: begin
                        r_state  <= ST_HUNT;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o1          = r_out[0];
    assign o2          = r_out[1];
    assign o3          = r_out[2];
    assign o4          = r_out[3];
    assign o5          = r_out[4];
    assign o6          = r_out[5];
    assign o7          = r_out[6];
    assign o8          = r_out[7];
    assign s0          = r_slot[2];
    assign s1          = r_slot[1];
    assign s2          = r_slot[0];
    assign frame_valid = r_frame_valid;
    assign locked      = r_locked;
    assign sync_err    = r_sync_err;

endmodule

// File: tb/tb_tdm_demux8x1.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux8x1
// Directed bench for tdm_demux8x1 with SYNC_LOSS=2. Frames are written as
// 8-bit constants with bit 0 = slot 0 = o1; fsync patterns likewise.
// -----------------------------------------------------------------------------
module tb_tdm_demux8x1;

    logic clk = 1'b0;
    logic rst_n;
    logic din;
    logic din_valid;
    logic fsync;
    logic o1, o2, o3, o4, o5, o6, o7, o8;
    logic s0, s1, s2;
    logic frame_valid;
    logic locked;
    logic sync_err;

    int total = 0;
    int bad   = 0;
    int fv_cnt = 0;
    int se_cnt = 0;

    logic [7:0] outs;
    logic [2:0] slot;
    assign outs = {o8, o7, o6, o5, o4, o3, o2, o1};
    assign slot = {s0, s1, s2};

    always #5 clk = ~clk;

    tdm_demux8x1 #(.SYNC_LOSS(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .fsync       (fsync),
        .o1          (o1),
        .o2          (o2),
        .o3          (o3),
        .o4          (o4),
        .o5          (o5),
        .o6          (o6),
        .o7          (o7),
        .o8          (o8),
        .s0          (s0),
        .s1          (s1),
        .s2          (s2),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // advance one clock, then sample pulse outputs away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
        fv_cnt += int'(frame_valid);
        se_cnt += int'(sync_err);
    endtask

    task automatic beat(input logic d, input logic f);
        din       = d;
        fsync     = f;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        fsync     = 1'b0;
    endtask

    // eight beats; with gap=1 an idle cycle follows each beat and the slot
    // counter is expected to hold through it
    task automatic send_frame(input logic [7:0] data, input logic [7:0] fs, input bit gap);
        for (int i = 0; i < 8; i++) begin
            beat(data[i], fs[i]);
            if (gap) begin
                tick();
                chk("gap_stall", {5'd0, slot}, 8'((i + 1) % 8));
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        fsync     = 1'b0;

        // 1. reset then idle
        tick();
        tick();
        chk("rst_outs",   outs, 8'h00);
        chk("rst_slot",   {5'd0, slot}, 8'h00);
        chk("rst_flags",  {5'd0, frame_valid, locked, sync_err}, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fsync = i[0];
            tick();
        end
        fsync = 1'b0;
        chk("idle_locked", {7'd0, locked}, 8'h00);

        // 2. clean frame 1,0,1,1,0,0,1,0
        fv_cnt = 0;
        se_cnt = 0;
        beat(1'b1, 1'b1);
        chk("t2_lock",    {7'd0, locked}, 8'h01);
        chk("t2_slot1",   {5'd0, slot}, 8'h01);
        for (int i = 1; i < 8; i++) begin
            logic [7:0] pat;
            pat = 8'h4D;
            beat(pat[i], 1'b0);
            if (i < 7) chk("t2_no_fv", {7'd0, frame_valid}, 8'h00);
        end
        chk("t2_fv",      {7'd0, frame_valid}, 8'h01);
        chk("t2_outs",    outs, 8'h4D);
        chk("t2_slot0",   {5'd0, slot}, 8'h00);
        tick();
        chk("t2_fv_pulse", {7'd0, frame_valid}, 8'h00);

        // 3. same frame with idle cycles between beats
        fv_cnt = 0;
        send_frame(8'h4D, 8'h01, 1'b1);
        chk("t3_outs",    outs, 8'h4D);
        chk("t3_fv_cnt",  8'(fv_cnt), 8'd1);

        // 4. flywheel: slot-0 fsync missing, then clean frames
        fv_cnt = 0;
        se_cnt = 0;
        send_frame(8'hA5, 8'h00, 1'b0);
        chk("t4_fly_outs", outs, 8'hA5);
        chk("t4_fly_lock", {7'd0, locked}, 8'h01);
        send_frame(8'h3C, 8'h01, 1'b0);
        chk("t4_good_outs", outs, 8'h3C);
        // a single miss after the clean frame must not drop lock
        send_frame(8'h96, 8'h00, 1'b0);
        chk("t4_miss_clr", outs, 8'h96);
        send_frame(8'hF0, 8'h01, 1'b0);
        chk("t4_fv_cnt",  8'(fv_cnt), 8'd4);
        chk("t4_se_cnt",  8'(se_cnt), 8'd0);

        // 5. loss with fsync=1 at slot 3: re-acquire on the same beat
        fv_cnt = 0;
        se_cnt = 0;
        beat(1'b1, 1'b0);               // slot 0, fsync missing: miss=1
        beat(1'b0, 1'b0);               // slot 1
        beat(1'b1, 1'b0);               // slot 2
        beat(1'b1, 1'b1);               // slot 3 with fsync: lock lost, realigned
        chk("t5_se",      {7'd0, sync_err}, 8'h01);
        chk("t5_no_fv",   {7'd0, frame_valid}, 8'h00);
        chk("t5_lock",    {7'd0, locked}, 8'h01);
        chk("t5_slot1",   {5'd0, slot}, 8'h01);
        tick();
        chk("t5_se_pulse", {7'd0, sync_err}, 8'h00);
        for (int i = 1; i < 8; i++) begin
            logic [7:0] pat;
            pat = 8'h2D;
            beat(pat[i], 1'b0);
        end
        chk("t5_outs",    outs, 8'h2D);
        chk("t5_fv_cnt",  8'(fv_cnt), 8'd1);
        chk("t5_se_cnt",  8'(se_cnt), 8'd1);

        // 5b. mismatch at slot 3, then fsync missing at slot 0: back to hunt
        se_cnt = 0;
        send_frame(8'h81, 8'h09, 1'b0);
        chk("t5b_outs",   outs, 8'h81);
        fv_cnt = 0;
        beat(1'b1, 1'b0);
        chk("t5b_se",     {7'd0, sync_err}, 8'h01);
        chk("t5b_unlock", {7'd0, locked}, 8'h00);
        chk("t5b_slot",   {5'd0, slot}, 8'h00);
        beat(1'b1, 1'b0);
        chk("t5b_hunt",   {7'd0, locked}, 8'h00);
        chk("t5b_hold",   outs, 8'h81);
        chk("t5b_fv_cnt", 8'(fv_cnt), 8'd0);

        // 6. reset after beat 4 of a frame
        fv_cnt = 0;
        beat(1'b0, 1'b1);
        for (int i = 1; i < 5; i++) beat(1'b1, 1'b0);
        chk("t6_pre_slot", {5'd0, slot}, 8'h05);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_outs",    outs, 8'h00);
        chk("t6_lock",    {7'd0, locked}, 8'h00);
        chk("t6_slot",    {5'd0, slot}, 8'h00);
        chk("t6_fv_cnt",  8'(fv_cnt), 8'd0);
        send_frame(8'h5A, 8'h01, 1'b0);
        chk("t6_outs2",   outs, 8'h5A);
        chk("t6_fv_cnt2", 8'(fv_cnt), 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux8x1.md
Name: tdm_demux8x1

Overview:
- Receive end of an 8-slot, 1-bit time-division multiplexed serial link.
- Recovers frame alignment from a frame-sync strobe and steps a 3-bit slot counter on each valid beat.
- Scatters each beat into a shadow register, then presents all 8 channel bits together on o1..o8 once per frame.
- Sits after the serial link; feeds per-channel consumers that need a whole frame at once.

Parameters:
- SYNC_LOSS, 2, consecutive fsync mismatches that drop lock. Legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- din  input  1  serial data bit for the current slot
- din_valid  input  1  din/fsync qualify this cycle
- fsync  input  1  high on the beat carrying slot 0; sampled only when din_valid=1
- o1..o8  output  1 each  channel bits of the last complete frame; slot 0 -> o1 … slot 7 -> o8
- s0,s1,s2  output  1 each  slot number expected on the next beat; s0 is MSB (s0s1s2=000 is slot 0, 001 is slot 1, …, 111 is slot 7)
- frame_valid  output  1  one-cycle pulse when o1..o8 update
- locked  output  1  high while in LOCKED
- sync_err  output  1  one-cycle pulse on loss of lock

Behaviour:
- Clock and reset are fixed: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at a clk edge):
  - o1..o8=0, s0..s2=000, frame_valid=0, locked=0, sync_err=0.
  - Shadow register=0, miss count=0, state=HUNT.
  - Applies mid-frame too: the partial frame is discarded and o1..o8 are cleared.
- All outputs are registered. Nothing advances and fsync is ignored when din_valid=0.
- Beat = a cycle with din_valid=1. Slot counter {s0,s1,s2} increments per LOCKED beat and wraps 7->0.
- HUNT:
  - Beat with fsync=1: shadow[0]=din, slot=1, miss=0, go LOCKED.
  - Beat with fsync=0: discarded.
- LOCKED, each beat:
  - Write shadow[slot]=din.
  - Mismatch = (fsync=1 and slot!=0) or (fsync=0 and slot=0).
  - Match at slot 0 (fsync=1, slot=0): miss=0.
  - Mismatch with miss+1 < SYNC_LOSS: miss+=1 and continue flywheel; data is still stored at the counter slot.
  - Mismatch with miss+1 = SYNC_LOSS:
    - Pulse sync_err, miss=0, discard the partial frame, no frame_valid.
    - If fsync=1 on this beat: re-acquire in the same cycle (shadow[0]=din, slot=1, stay LOCKED, locked stays 1).
    - If fsync=0: go HUNT, slot=000, locked=0.
  - Beat at slot 7 without loss:
    - o1..o8 <= {shadow[0..6], din}.
    - frame_valid=1 for one cycle.
    - slot wraps to 0.
- Latency: slot 7 beat at edge N -> o1..o8 and frame_valid visible after edge N (cycle N+1).
- o1..o8 hold their value between frames and through HUNT.
- Back-to-back frames with no gaps give frame_valid every 8 cycles.
- sync_err and frame_valid are never high together. locked=0 implies s0..s2=000.

Test Plan:
1. Reset then idle:
   - rst_n=0 for 2 cycles, din_valid=0.
   - Required: all outputs 0, locked=0; fsync toggling with din_valid=0 keeps locked=0.
2. Clean frame:
   - fsync on beat 0, din=1,0,1,1,0,0,1,0 on 8 consecutive beats.
   - Required: locked=1 after beat 0; frame_valid pulses one cycle after beat 7; o1..o8=1,0,1,1,0,0,1,0; s0..s2=000.
3. Gapped beats:
   - Same frame as test 2 with din_valid=0 inserted between every beat.
   - Required: identical o1..o8; frame_valid exactly once; slot stalls during gaps.
4. Flywheel, SYNC_LOSS=2:
   - Frame with fsync missing on slot 0, then a correct frame.
   - Required: both frames delivered, sync_err stays 0, miss count cleared by the second frame.
5. Loss and re-acquire:
   - Two consecutive mismatches, the second being fsync=1 at slot 3.
   - Required: sync_err one-cycle pulse, no frame_valid; that beat is stored as slot 0 and the next 7 beats complete a frame.
   - Variant with fsync=0 on the second mismatch: locked drops to 0 and the state returns to HUNT.
6. Reset mid-frame:
   - rst_n=0 after beat 4 of a frame.
   - Required: o1..o8=0, locked=0, no frame_valid; a fresh fsync-led frame then decodes correctly.
